// File: rtl/reg_bus_bridge.sv
// reg_bus_bridge: command FIFO plus access sequencer in front of the SD host
// register set. Host commands are queued and replayed one at a time on the
// req/wnr/address/data_in port. The bridge then waits for ack, or aborts after
// TIMEOUT sampling edges. Read results go back on a valid/ready response port.
// A write that times out sets a sticky error flag.
module reg_bus_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wnr,
    input  logic [7:0] cmd_address,
    input  logic [7:0] cmd_wdata,
    output logic       req,
    output logic       wnr,
    output logic [7:0] address,
    output logic [7:0] data_in,
    input  logic       ack,
    input  logic [7:0] data_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic       wr_err,
    input  logic       err_clr,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    // Counter value at which one more missing ack means abort
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic       wnr;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    cmd_t          fifo_q [FIFO_DEPTH];
    cmd_t          fifo_d [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          wnr_q, wnr_d;
    logic [7:0]    address_q, address_d;
    logic [7:0]    data_in_q, data_in_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_error_q, rsp_error_d;
    logic          wr_err_q, wr_err_d;
    logic          busy_q, busy_d;

    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          push_s;
    cmd_t          head_s;

    // The extra pointer MSB separates a full FIFO from an empty one
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_s       = cmd_valid & ~fifo_full_s;
    assign head_s       = fifo_q[rd_ptr_q[AW-1:0]];

    // Next-state logic for the FIFO, the access sequencer and all registered outputs
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        wnr_d       = wnr_q;
        address_d   = address_q;
        data_in_d   = data_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        wr_err_d    = wr_err_q;
        busy_d      = (!fifo_empty_s) || (state_q != ST_IDLE);

        if (push_s) begin
            fifo_d[wr_ptr_q[AW-1:0]] = '{wnr: cmd_wnr, addr: cmd_address, data: cmd_wdata};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // A clear request is applied first so a same-edge write timeout overrides it
        if (err_clr) begin
            wr_err_d = 1'b0;
        end else begin
            wr_err_d = wr_err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    wnr_d     = head_s.wnr;
                    address_d = head_s.addr;
                    data_in_d = head_s.data;
                    req_d     = 1'b1;
                    cnt_d     = {CW{1'b0}};
                    state_d   = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ack) begin
                    req_d = 1'b0;
                    if (!wnr_q) begin
                        rsp_data_d  = data_out;
                        rsp_error_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                    if (!wnr_q) begin
                        rsp_data_d  = 8'h00;
                        rsp_error_d = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        wr_err_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops req at once and discards queue and response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            wnr_q       <= 1'b0;
            address_q   <= 8'h00;
            data_in_q   <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
            wr_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            wnr_q       <= wnr_d;
            address_q   <= address_d;
            data_in_q   <= data_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            wr_err_q    <= wr_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = ~fifo_full_s;
    assign req       = req_q;
    assign wnr       = wnr_q;
    assign address   = address_q;
    assign data_in   = data_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign wr_err    = wr_err_q;
    assign busy      = busy_q;

endmodule
